router_dst_port: RTL and testbench
==================================

# router_dst_port

Parametrised destination output port for the router: a packet-aware synchronous FIFO with a valid/read handshake toward the destination agent and a read-timeout soft reset. One instance sits between the router's write-side control and each destination channel. It generalises the fixed 8-bit, 16-deep channel buffer to arbitrary data width, depth and timeout. It adds packet-length tracking, last-byte indication and an occupancy count.

## Interface
- DATA_W, 8, data byte width; header length field is bits [DATA_W-1:2]
- DEPTH, 16, FIFO entries; power of two, 4..256
- TIMEOUT, 30, consecutive stalled cycles before soft reset; 1..1023
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- wr_en  in  1  write request from router control
- lfd  in  1  marks data_in as a packet header byte
- data_in  in  DATA_W  write data
- read_enb  in  1  destination read strobe
- data_out  out  DATA_W  registered read data
- valid_out  out  1  FIFO non-empty
- full  out  1  FIFO full
- count  out  $clog2(DEPTH)+1  current occupancy
- last_out  out  1  data_out holds the final (parity) byte of a packet
- soft_reset  out  1  one-cycle pulse: timeout flush

## Operation
- Storage: DEPTH x (DATA_W+1); the extra bit stores lfd alongside each byte.
- Write: accepted when wr_en && !full, evaluated on pre-edge state. Writes while full are dropped silently.
- Read: accepted when read_enb && valid_out. The entry moves to data_out on the same edge, and data_out holds its value otherwise.
- Packet tracking on the read side:
  - A popped entry with lfd=1 loads rem = data[DATA_W-1:2] + 1. This counts payload bytes plus parity.
  - Each later pop decrements rem. last_out is set with the pop that brings rem from 1 to 0.
- Length 0 header: the next pop is the parity byte and sets last_out.
- Timeout counter:
  - Increments each cycle with valid_out && !read_enb.
  - Clears on any accepted read, and whenever valid_out=0.
  - On reaching TIMEOUT-1 with the stall still present, soft_reset pulses next cycle.
  - On that same edge the flush happens: pointers, count, rem and timer go to 0, and data_out and last_out go to 0.
- Simultaneous events:
  - Read+write while full: both are accepted, count unchanged.
  - Read+write while empty: only the write is accepted.
  - Flush coincident with wr_en: the flush wins and the write is dropped.
- Pointers are $clog2(DEPTH)+1 bits. Wrap-around uses the MSB to distinguish full from empty.

## Timing
- Reset values: data_out=0, valid_out=0, full=0, count=0, last_out=0, soft_reset=0. All internal state is 0.
- Reset is asynchronous on assertion and takes effect immediately mid-packet. Release is synchronous to clock.
- Write-to-valid_out latency: 1 cycle (valid_out is a combinational decode of registered count).
- Read latency: data_out is valid 1 cycle after the accepting edge.
- full and count update on the edge of the accepting write or read.
- Soft-reset: with constant stall, soft_reset is high in cycle TIMEOUT after valid_out first rises with read_enb low. The FIFO is empty in the following cycle.

## Structure
- Shared package router_pkg holds:
  - the default DATA_W/DEPTH/TIMEOUT constants
  - LEN_LSB=2
  - the function computing the packet byte count from a header
- The timeout counter width is $clog2(TIMEOUT+1), local to the module.
- Sub-module router_sync_fifo_mem: dual-port register array with write enable and read address. All pointer, count, timer and packet logic stays in router_dst_port.

## Test plan
- Reset then write header 0x0C (len 3), 3 payload bytes and parity at consecutive edges. Then hold read_enb for 5 cycles. Required: count 5→0, bytes exit in order at 1-cycle latency, and last_out=1 only with the parity byte.
- Fill to DEPTH=16 and assert wr_en once more. Required: full=1, count=16, and the extra byte is absent on readback. Then read+write in the same cycle: count stays 16.
- Empty FIFO, wr_en and read_enb in the same cycle. Required: count=1, and data_out unchanged.
- Write 2 bytes and hold read_enb=0 with TIMEOUT=30. Required: soft_reset pulses exactly once, 30 cycles after valid_out rises. Next cycle count=0, valid_out=0, data_out=0.
- Stall 29 cycles, read once, then stall again. Required: no soft_reset until 30 further stalled cycles.
- Deassert resetn mid-packet with count=7. Required: all outputs 0 immediately; after release, a new header with len 0 gives last_out on the second pop.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants and header helpers for the router destination ports.
package router_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int DEPTH_DEF   = 16;
    localparam int TIMEOUT_DEF = 30;
    localparam int LEN_LSB     = 2;

    // Bytes that follow a header: payload length plus the trailing parity byte.
    function automatic logic [31:0] pkt_byte_count(input logic [31:0] hdr);
        return (hdr >> LEN_LSB) + 32'd1;
    endfunction

endpackage

// File: rtl/router_sync_fifo_mem.sv
// Register-array storage for the destination FIFO: one write port, one asynchronous read port.
module router_sync_fifo_mem #(
    parameter int AW = 4,
    parameter int W  = 9
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    localparam int N = 1 << AW;

    logic [W-1:0] mem_r [N];

    // Storage array write; cleared on reset so no stale entry survives.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/router_dst_port.sv
// Destination output port: packet-aware FIFO with valid/read handshake,
// last-byte tracking and a stalled-read timeout flush.
module router_dst_port
    import router_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       wr_en,
    input  logic                       lfd,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       read_enb,
    output logic [DATA_W-1:0]          data_out,
    output logic                       valid_out,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       last_out,
    output logic                       soft_reset
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int REM_W = DATA_W - LEN_LSB + 1;

    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  count_r;
    logic [TMR_W-1:0]  timer_r;
    logic [REM_W-1:0]  rem_r;
    logic [DATA_W-1:0] data_out_r;
    logic              last_out_r;
    logic              soft_reset_r;

    logic [DATA_W:0]   rd_entry_s;
    logic [REM_W-1:0]  rem_load_s;
    logic              valid_s;
    logic              full_s;
    logic              rd_acc_s;
    logic              wr_acc_s;
    logic              stall_s;
    logic              flush_s;

    assign valid_s  = (count_r != {PTR_W{1'b0}});
    assign full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign stall_s  = valid_s && !read_enb;
    assign flush_s  = stall_s && (timer_r == TMR_W'(TIMEOUT - 1));
    assign rd_acc_s = read_enb && valid_s;
    // A pop frees the slot on the same edge, so a full FIFO still takes a write alongside a read.
    assign wr_acc_s = wr_en && (!full_s || rd_acc_s) && !flush_s;

    assign rem_load_s = REM_W'(pkt_byte_count(32'(rd_entry_s[DATA_W-1:0])));

    router_sync_fifo_mem #(
        .AW (AW),
        .W  (DATA_W + 1)
    ) u_mem (
        .clock   (clock),
        .resetn  (resetn),
        .wr_en   (wr_acc_s),
        .wr_addr (wr_ptr_r[AW-1:0]),
        .wr_data ({lfd, data_in}),
        .rd_addr (rd_ptr_r[AW-1:0]),
        .rd_data (rd_entry_s)
    );

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {PTR_W{1'b0}};
        end else if (flush_s) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {PTR_W{1'b0}};
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_r <= count_r + PTR_W'(1);
                2'b01:   count_r <= count_r - PTR_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Stall timer and the one-cycle timeout pulse.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            timer_r      <= {TMR_W{1'b0}};
            soft_reset_r <= 1'b0;
        end else begin
            soft_reset_r <= flush_s;
            if (stall_s && !flush_s) begin
                timer_r <= timer_r + TMR_W'(1);
            end else begin
                timer_r <= {TMR_W{1'b0}};
            end
        end
    end

    // Read data register and remaining-bytes tracking for last_out.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_out_r <= {DATA_W{1'b0}};
            last_out_r <= 1'b0;
            rem_r      <= {REM_W{1'b0}};
        end else if (flush_s) begin
            data_out_r <= {DATA_W{1'b0}};
            last_out_r <= 1'b0;
            rem_r      <= {REM_W{1'b0}};
        end else if (rd_acc_s) begin
            data_out_r <= rd_entry_s[DATA_W-1:0];
            if (rd_entry_s[DATA_W]) begin
                rem_r      <= rem_load_s;
                last_out_r <= 1'b0;
            end else if (rem_r != {REM_W{1'b0}}) begin
                rem_r      <= rem_r - REM_W'(1);
                last_out_r <= (rem_r == REM_W'(1));
            end else begin
                last_out_r <= 1'b0;
            end
        end
    end

    assign data_out   = data_out_r;
    assign last_out   = last_out_r;
    assign soft_reset = soft_reset_r;
    assign valid_out  = valid_s;
    assign full       = full_s;
    assign count      = count_r;

endmodule

// File: tb/tb_router_dst_port.sv
// Self-checking bench for router_dst_port against a queue-based behavioural model.
module tb_router_dst_port;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int TO    = 30;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          wr_en = 1'b0;
    logic          lfd = 1'b0;
    logic [DW-1:0] data_in = 8'h00;
    logic          read_enb = 1'b0;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          full;
    logic [4:0]    count;
    logic          last_out;
    logic          soft_reset;

    int checks = 0;
    int failures = 0;

    // Behavioural model: stored entries, remaining packet bytes, stall run length.
    bit [8:0]      q[$];
    int            m_rem = 0;
    logic [DW-1:0] m_dout = 8'h00;
    bit            m_last = 1'b0;
    bit            m_sr = 1'b0;
    int            m_stall = 0;

    router_dst_port #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .wr_en      (wr_en),
        .lfd        (lfd),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .full       (full),
        .count      (count),
        .last_out   (last_out),
        .soft_reset (soft_reset)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        q.delete();
        m_rem = 0; m_dout = 8'h00; m_last = 1'b0; m_sr = 1'b0; m_stall = 0;
    endtask

    // One clock edge: advance the model from the inputs held across the edge.
    task automatic tick();
        bit valid, rd, wr, flush;
        bit [8:0] e;
        valid = (q.size() != 0);
        rd    = read_enb && valid;
        wr    = wr_en && (q.size() < DEPTH || rd);
        flush = valid && !read_enb && (m_stall == TO - 1);
        @(posedge clock);
        if (flush) begin
            q.delete();
            m_rem = 0; m_dout = 8'h00; m_last = 1'b0; m_stall = 0; m_sr = 1'b1;
        end else begin
            m_sr = 1'b0;
            if (rd) begin
                e = q.pop_front();
                m_dout = e[7:0];
                if (e[8]) begin
                    m_rem  = int'(e[7:2]) + 1;
                    m_last = 1'b0;
                end else if (m_rem > 0) begin
                    m_last = (m_rem == 1);
                    m_rem--;
                end else begin
                    m_last = 1'b0;
                end
            end
            if (wr) q.push_back({lfd, data_in});
            m_stall = (!valid || rd) ? 0 : m_stall + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks += 6;
        if (data_out !== 8'h00)  begin failures++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
        if (valid_out !== 1'b0)  begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
        if (full !== 1'b0)       begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        if (count !== 5'd0)      begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        if (last_out !== 1'b0)   begin failures++; $display("FAIL reset_last got=%b exp=0", last_out); end
        if (soft_reset !== 1'b0) begin failures++; $display("FAIL reset_soft got=%b exp=0", soft_reset); end
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        model_reset();
    endtask

    task automatic test_packet();
        logic [DW-1:0] pkt [5];
        pkt[0] = 8'h0C;
        for (int i = 1; i < 5; i++) pkt[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; lfd = (i == 0); data_in = pkt[i];
            tick();
            checks++;
            if (count !== 5'(i + 1)) begin failures++; $display("FAIL pkt_wr_count i=%0d got=%0d exp=%0d", i, count, i + 1); end
        end
        wr_en = 1'b0; lfd = 1'b0; read_enb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks += 3;
            if (data_out !== pkt[i])          begin failures++; $display("FAIL pkt_data i=%0d got=%h exp=%h", i, data_out, pkt[i]); end
            if (last_out !== (i == 4))        begin failures++; $display("FAIL pkt_last i=%0d got=%b exp=%b", i, last_out, (i == 4)); end
            if (count !== 5'(4 - i))          begin failures++; $display("FAIL pkt_rd_count i=%0d got=%0d exp=%0d", i, count, 4 - i); end
        end
        read_enb = 1'b0;
    endtask

    task automatic test_full();
        logic [DW-1:0] stored [DEPTH];
        logic [DW-1:0] extra;
        for (int i = 0; i < DEPTH + 1; i++) begin
            wr_en = 1'b1; lfd = 1'b0; data_in = 8'($urandom);
            if (i < DEPTH) stored[i] = data_in;
            tick();
        end
        checks += 2;
        if (full !== 1'b1)  begin failures++; $display("FAIL full_flag got=%b exp=1", full); end
        if (count !== 5'd16) begin failures++; $display("FAIL full_count got=%0d exp=16", count); end
        read_enb = 1'b1; extra = 8'($urandom); data_in = extra;
        tick();
        checks += 3;
        if (count !== 5'd16)       begin failures++; $display("FAIL full_rw_count got=%0d exp=16", count); end
        if (full !== 1'b1)         begin failures++; $display("FAIL full_rw_flag got=%b exp=1", full); end
        if (data_out !== stored[0]) begin failures++; $display("FAIL full_rw_data got=%h exp=%h", data_out, stored[0]); end
        wr_en = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            checks++;
            if (i < DEPTH) begin
                if (data_out !== stored[i]) begin failures++; $display("FAIL full_drain i=%0d got=%h exp=%h", i, data_out, stored[i]); end
            end else begin
                if (data_out !== extra) begin failures++; $display("FAIL full_drain_last got=%h exp=%h", data_out, extra); end
            end
        end
        read_enb = 1'b0;
        checks++;
        if (count !== 5'd0) begin failures++; $display("FAIL full_drained_count got=%0d exp=0", count); end
    endtask

    task automatic test_empty_rw();
        logic [DW-1:0] prev, b;
        prev = data_out;
        b = 8'($urandom);
        wr_en = 1'b1; read_enb = 1'b1; lfd = 1'b0; data_in = b;
        tick();
        checks += 2;
        if (count !== 5'd1)   begin failures++; $display("FAIL empty_rw_count got=%0d exp=1", count); end
        if (data_out !== prev) begin failures++; $display("FAIL empty_rw_data got=%h exp=%h", data_out, prev); end
        wr_en = 1'b0;
        tick();
        checks += 2;
        if (data_out !== b)  begin failures++; $display("FAIL empty_rw_pop got=%h exp=%h", data_out, b); end
        if (count !== 5'd0)  begin failures++; $display("FAIL empty_rw_after got=%0d exp=0", count); end
        read_enb = 1'b0;
    endtask

    task automatic test_timeout();
        int cyc, pulses, pulse_cyc;
        pulses = 0; pulse_cyc = -1;
        wr_en = 1'b1; lfd = 1'b0; data_in = 8'($urandom);
        tick();
        cyc = 0;
        while (cyc < 34) begin
            wr_en = (cyc == 0) || (m_stall == TO - 1);
            data_in = 8'($urandom);
            tick();
            cyc++;
            checks++;
            if (soft_reset !== m_sr) begin failures++; $display("FAIL to_soft cyc=%0d got=%b exp=%b", cyc, soft_reset, m_sr); end
            if (soft_reset === 1'b1) begin pulses++; pulse_cyc = cyc; end
            if (cyc == TO + 1) begin
                checks += 3;
                if (count !== 5'd0)     begin failures++; $display("FAIL to_count got=%0d exp=0", count); end
                if (valid_out !== 1'b0) begin failures++; $display("FAIL to_valid got=%b exp=0", valid_out); end
                if (data_out !== 8'h00) begin failures++; $display("FAIL to_data got=%h exp=00", data_out); end
            end
        end
        wr_en = 1'b0;
        checks += 2;
        if (pulses != 1)      begin failures++; $display("FAIL to_pulses got=%0d exp=1", pulses); end
        if (pulse_cyc != TO)  begin failures++; $display("FAIL to_pulse_cycle got=%0d exp=%0d", pulse_cyc, TO); end
    endtask

    task automatic test_stall_read();
        int cyc, pulse_cyc;
        pulse_cyc = -1;
        wr_en = 1'b1; lfd = 1'b0; data_in = 8'($urandom);
        tick();
        cyc = 0;
        while (cyc < 62) begin
            wr_en = (cyc < 2); data_in = 8'($urandom);
            read_enb = (cyc == TO - 1);
            tick();
            cyc++;
            checks++;
            if (soft_reset !== m_sr) begin failures++; $display("FAIL sr_soft cyc=%0d got=%b exp=%b", cyc, soft_reset, m_sr); end
            if (soft_reset === 1'b1 && pulse_cyc < 0) pulse_cyc = cyc;
        end
        wr_en = 1'b0; read_enb = 1'b0;
        checks++;
        if (pulse_cyc != 2 * TO) begin failures++; $display("FAIL sr_pulse_cycle got=%0d exp=%0d", pulse_cyc, 2 * TO); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] par;
        for (int i = 0; i < 7; i++) begin
            wr_en = 1'b1; lfd = (i == 0); data_in = (i == 0) ? 8'h18 : 8'($urandom);
            tick();
        end
        wr_en = 1'b0; lfd = 1'b0; read_enb = 1'b1;
        tick();
        read_enb = 1'b0; wr_en = 1'b1; data_in = 8'($urandom);
        tick();
        wr_en = 1'b0;
        checks++;
        if (count !== 5'd7) begin failures++; $display("FAIL mid_count_pre got=%0d exp=7", count); end
        #2 resetn = 1'b0;
        #1;
        checks += 5;
        if (data_out !== 8'h00) begin failures++; $display("FAIL mid_data got=%h exp=00", data_out); end
        if (valid_out !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", valid_out); end
        if (count !== 5'd0)     begin failures++; $display("FAIL mid_count got=%0d exp=0", count); end
        if (full !== 1'b0)      begin failures++; $display("FAIL mid_full got=%b exp=0", full); end
        if (last_out !== 1'b0)  begin failures++; $display("FAIL mid_last got=%b exp=0", last_out); end
        model_reset();
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        wr_en = 1'b1; lfd = 1'b1; data_in = {6'd0, 2'($urandom)};
        tick();
        par = 8'($urandom);
        lfd = 1'b0; data_in = par;
        tick();
        wr_en = 1'b0; read_enb = 1'b1;
        tick();
        checks++;
        if (last_out !== 1'b0) begin failures++; $display("FAIL len0_first_last got=%b exp=0", last_out); end
        tick();
        read_enb = 1'b0;
        checks += 2;
        if (last_out !== 1'b1) begin failures++; $display("FAIL len0_second_last got=%b exp=1", last_out); end
        if (data_out !== par)  begin failures++; $display("FAIL len0_parity got=%h exp=%h", data_out, par); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            wr_en    = ($urandom_range(0, 2) != 0);
            lfd      = ($urandom_range(0, 7) == 0);
            data_in  = 8'($urandom);
            read_enb = ((i / 100) % 2 == 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
            tick();
            checks += 6;
            if (count !== 5'(q.size())) begin failures++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, count, q.size()); end
            if (valid_out !== (q.size() != 0)) begin failures++; $display("FAIL rnd_valid i=%0d got=%b", i, valid_out); end
            if (full !== (q.size() == DEPTH))  begin failures++; $display("FAIL rnd_full i=%0d got=%b", i, full); end
            if (data_out !== m_dout)  begin failures++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, data_out, m_dout); end
            if (last_out !== m_last)  begin failures++; $display("FAIL rnd_last i=%0d got=%b exp=%b", i, last_out, m_last); end
            if (soft_reset !== m_sr)  begin failures++; $display("FAIL rnd_soft i=%0d got=%b exp=%b", i, soft_reset, m_sr); end
        end
        wr_en = 1'b0; read_enb = 1'b0; lfd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_packet();
        test_full();
        test_empty_rw();
        test_timeout();
        test_stall_read();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
